// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO register pair with an iterative radix-2 multiply/divide engine.
// MULT/MULTU/DIV/DIVU run on unsigned magnitudes for 32 steps, then a FIX step
// applies the sign correction and writes HI/LO. MTHI/MTLO write directly from IDLE.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [63:0] acc_q, acc_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [31:0] dvs_q, dvs_d;
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        dz_q, dz_d;
    logic [31:0] rs_q, rs_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    op_t         op_in;
    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_cand;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign op_in = op_t'(op);

    // Datapath helpers: operand magnitudes, one iteration step, and sign-corrected results.
    always_comb begin
        op_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
        a_neg     = op_signed & rs_val[31];
        b_neg     = op_signed & rt_val[31];
        a_mag     = a_neg ? (~rs_val + 32'd1) : rs_val;
        b_mag     = b_neg ? (~rt_val + 32'd1) : rt_val;

        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};

        // Remainder shifted left by one with the next dividend bit brought in;
        // the 33rd bit keeps the comparison exact when the remainder's MSB is set.
        div_cand  = {acc_q[63:32], acc_q[31]};
        div_diff  = div_cand - {1'b0, dvs_q};
        if (div_cand >= {1'b0, dvs_q}) begin
            div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            div_next = {div_cand[31:0], acc_q[30:0], 1'b0};
        end

        prod_fix  = neg_lo_q ? (~acc_q + 64'd1) : acc_q;
        quot_fix  = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix   = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    end

    // Next-state and register updates for the IDLE/CALC/FIX sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvs_d    = dvs_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        rs_d     = rs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op_in)
                        OP_MULT, OP_MULTU: begin
                            acc_d    = {32'd0, b_mag};
                            dvs_d    = a_mag;
                            is_div_d = 1'b0;
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = 1'b0;
                            dz_d     = 1'b0;
                            rs_d     = rs_val;
                            cnt_d    = '0;
                            state_d  = S_CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d    = {32'd0, a_mag};
                            dvs_d    = b_mag;
                            is_div_d = 1'b1;
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = a_neg;
                            dz_d     = (rt_val == 32'd0);
                            rs_d     = rs_val;
                            cnt_d    = '0;
                            state_d  = S_CALC;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = rs_q;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            rs_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvs_q    <= dvs_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            rs_q     <= rs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed and randomized checks of hilo_muldiv_unit against
// an arithmetic reference model of HI/LO.
module tb_hilo_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;

    int          checks;
    int          failures;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    hilo_muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .HI     (HI),
        .LO     (LO),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: architectural effect of one issued op on HI/LO.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin
                p = 64'(sa * sb);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                end else if (o == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op and follow it to completion; optionally fire ignored starts while busy,
    // optionally release reset on the same edge start is presented.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, input bit rel);
        logic [63:0] old;
        int          n;
        int          dones;
        bit          md;
        old = {exp_hi, exp_lo};
        md  = (o < 3'd4);
        model(o, a, b);
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        op     = 3'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
        if (md) begin
            n = 0;
            dones = 0;
            while (busy && n < 40) begin
                check_eq("hold_during_busy", {HI, LO}, old);
                if (done) dones++;
                if (inject && n == 12) begin
                    start = 1'b1; op = 3'd5; rs_val = $urandom;
                end else if (inject && n == 32) begin
                    start = 1'b1; op = 3'd4; rs_val = $urandom;
                end else begin
                    start = 1'b0;
                end
                n++;
                @(negedge clk);
            end
            start = 1'b0;
            check_eq("busy_cycles", 64'(n), 64'd33);
            check_eq("done_during_busy", 64'(dones), 64'd0);
            check_eq("done_pulse", {63'd0, done}, 64'd1);
            check_eq("result", {HI, LO}, {exp_hi, exp_lo});
            @(negedge clk);
            check_eq("done_single", {63'd0, done}, 64'd0);
            check_eq("result_hold", {HI, LO}, {exp_hi, exp_lo});
        end else begin
            check_eq("busy_low", {63'd0, busy}, 64'd0);
            check_eq("done_low", {63'd0, done}, 64'd0);
            check_eq("move_result", {HI, LO}, {exp_hi, exp_lo});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        checks   = 0;
        failures = 0;
        exp_hi   = '0;
        exp_lo   = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = '0;
        rs_val   = '0;
        rt_val   = '0;
        #23;
        check_eq("reset_hilo", {HI, LO}, 64'd0);
        check_eq("reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check_eq("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        do_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0);
        check_eq("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        check_eq("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd3, 32'h0000_0064, 32'h0000_0000, 0, 0);
        check_eq("divu_zero", {HI, LO}, 64'h0000_0064_FFFF_FFFF);
        do_op(3'd2, 32'h8000_0005, 32'h0000_0000, 0, 0);
        check_eq("div_zero", {HI, LO}, 64'h8000_0005_FFFF_FFFF);
        do_op(3'd4, 32'h1234_5678, 32'h0, 0, 0);
        check_eq("mthi", {32'd0, HI}, 64'h1234_5678);
        do_op(3'd2, 32'h0000_0064, 32'h0000_0007, 1, 0);
        check_eq("div_ignores_start", {HI, LO}, 64'h0000_0002_0000_000E);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check_eq("div_overflow", {HI, LO}, 64'h0000_0000_8000_0000);
        do_op(3'd6, 32'hDEAD_BEEF, 32'h1, 0, 0);
        do_op(3'd7, 32'hCAFE_F00D, 32'h1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: rb = -32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 100));
            do_op(ro, ra, rb, bit'($urandom_range(0, 1)), 0);
        end

        do_op(3'd4, 32'hA5A5_A5A5, 32'h0, 0, 0);
        do_op(3'd5, 32'h5A5A_5A5A, 32'h0, 0, 0);
        @(negedge clk);
        start  = 1'b1;
        op     = 3'd2;
        rs_val = $urandom;
        rt_val = $urandom | 32'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_reset_hilo", {HI, LO}, 64'd0);
        check_eq("async_reset_busy_done", {62'd0, busy, done}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        do_op(3'd1, 32'd3, 32'd5, 0, 1);
        check_eq("multu_after_reset", {HI, LO}, 64'h0000_0000_0000_000F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
